// File: rtl/spi_cmd_sequencer.sv
// Command front-end for the SPI engine: parses framed host commands, preloads the TX FIFO,
// launches one SPI transaction, drains RX bytes back to the host and closes with a status byte.
module spi_cmd_sequencer #(
    parameter int unsigned DATA          = 8,
    parameter int unsigned START_TIMEOUT = 4,
    parameter int unsigned RX_TIMEOUT    = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [DATA-1:0] in_data_i,
    input  logic            in_valid_i,
    output logic            in_ready_o,
    output logic [DATA-1:0] out_data_o,
    output logic            out_valid_o,
    input  logic            out_ready_i,
    output logic [DATA-1:0] txf_wdata_o,
    output logic            txf_wr_o,
    input  logic            txf_full_i,
    input  logic [DATA-1:0] rxf_rdata_i,
    output logic            rxf_rd_o,
    input  logic            rxf_empty_i,
    output logic [15:0]     len_o,
    output logic            op_o,
    output logic            work_o,
    input  logic            busy_i
);

    typedef enum logic [3:0] {
        StHdr0, StHdr1, StHdr2, StCheck, StLoad, StStart, StWaitHi, StWaitLo, StDrain, StStat
    } state_e;

    localparam logic [DATA-1:0] StatusOk     = DATA'(8'h00);
    localparam logic [DATA-1:0] StatusBadHdr = DATA'(8'hE1);
    localparam logic [DATA-1:0] StatusNoBusy = DATA'(8'hE2);
    localparam logic [DATA-1:0] StatusRxTmo  = DATA'(8'hE3);
    localparam logic [15:0]     StartTmoLast = 16'(START_TIMEOUT - 1);
    localparam logic [15:0]     RxTmoLast    = 16'(RX_TIMEOUT - 1);

    state_e          state_q, state_d;
    logic [DATA-1:0] cmd_q, cmd_d;
    logic [15:0]     hdr_len_q, hdr_len_d;
    logic [15:0]     len_q, len_d;
    logic            op_q, op_d;
    logic [15:0]     tx_cnt_q, tx_cnt_d;
    logic [15:0]     rx_cnt_q, rx_cnt_d;
    logic [DATA-1:0] status_q, status_d;
    logic [15:0]     tmo_q, tmo_d;

    logic            hdr_bad;
    logic [15:0]     wr_bytes;
    logic [15:0]     rd_bytes;

    assign hdr_bad  = (cmd_q[DATA-1:1] != '0) || (hdr_len_q == 16'd0) ||
                      (!cmd_q[0] && ((hdr_len_q < 16'd32) || (hdr_len_q[2:0] != 3'd0)));
    assign wr_bytes = 16'((32'(hdr_len_q) + 32'd7) >> 3);
    assign rd_bytes = (hdr_len_q - 16'd24) >> 3;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StHdr0;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cmd_q     <= '0;
            hdr_len_q <= '0;
            len_q     <= '0;
            op_q      <= 1'b0;
            tx_cnt_q  <= '0;
            rx_cnt_q  <= '0;
            status_q  <= '0;
            tmo_q     <= '0;
        end else begin
            cmd_q     <= cmd_d;
            hdr_len_q <= hdr_len_d;
            len_q     <= len_d;
            op_q      <= op_d;
            tx_cnt_q  <= tx_cnt_d;
            rx_cnt_q  <= rx_cnt_d;
            status_q  <= status_d;
            tmo_q     <= tmo_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cmd_d     = cmd_q;
        hdr_len_d = hdr_len_q;
        len_d     = len_q;
        op_d      = op_q;
        tx_cnt_d  = tx_cnt_q;
        rx_cnt_d  = rx_cnt_q;
        status_d  = status_q;
        tmo_d     = tmo_q + 16'd1;
        case (state_q)
            StHdr0: if (in_valid_i && in_ready_o) begin
                cmd_d   = in_data_i;
                state_d = StHdr1;
            end
            StHdr1: if (in_valid_i && in_ready_o) begin
                hdr_len_d[15:8] = in_data_i;
                state_d         = StHdr2;
            end
            StHdr2: if (in_valid_i && in_ready_o) begin
                hdr_len_d[7:0] = in_data_i;
                state_d        = StCheck;
            end
            StCheck: begin
                len_d    = hdr_len_q;
                op_d     = cmd_q[0];
                tx_cnt_d = cmd_q[0] ? wr_bytes : 16'd3;
                rx_cnt_d = cmd_q[0] ? 16'd0 : rd_bytes;
                if (hdr_bad) begin
                    status_d = StatusBadHdr;
                    state_d  = StStat;
                end else begin
                    state_d = StLoad;
                end
            end
            StLoad: if (txf_wr_o) begin
                tx_cnt_d = tx_cnt_q - 16'd1;
                if (tx_cnt_q == 16'd1) state_d = StStart;
            end
            StStart: state_d = StWaitHi;
            StWaitHi: begin
                if (busy_i) begin
                    state_d = StWaitLo;
                end else if (tmo_q == StartTmoLast) begin
                    status_d = StatusNoBusy;
                    state_d  = StStat;
                end
            end
            StWaitLo: if (!busy_i) begin
                if (rx_cnt_q != 16'd0) begin
                    state_d = StDrain;
                end else begin
                    status_d = StatusOk;
                    state_d  = StStat;
                end
            end
            StDrain: begin
                // Timeout only accumulates over consecutive empty cycles.
                if (!rxf_empty_i) tmo_d = '0;
                if (rxf_rd_o) begin
                    rx_cnt_d = rx_cnt_q - 16'd1;
                    if (rx_cnt_q == 16'd1) begin
                        status_d = StatusOk;
                        state_d  = StStat;
                    end
                end else if (rxf_empty_i && (tmo_q == RxTmoLast)) begin
                    status_d = StatusRxTmo;
                    state_d  = StStat;
                end
            end
            StStat: if (out_ready_i) state_d = StHdr0;
            default: state_d = StHdr0;
        endcase
        if (state_d != state_q) tmo_d = '0;
    end

    // Outputs are forced idle while rst is high so reset takes effect in the same cycle.
    always_comb begin
        in_ready_o  = 1'b0;
        out_valid_o = 1'b0;
        out_data_o  = '0;
        txf_wr_o    = 1'b0;
        rxf_rd_o    = 1'b0;
        work_o      = 1'b0;
        if (!rst) begin
            case (state_q)
                StHdr0, StHdr1, StHdr2: in_ready_o = 1'b1;
                StLoad: begin
                    in_ready_o = !txf_full_i;
                    txf_wr_o   = in_valid_i && !txf_full_i;
                end
                StStart: work_o = 1'b1;
                StDrain: begin
                    out_valid_o = !rxf_empty_i;
                    out_data_o  = rxf_rdata_i;
                    rxf_rd_o    = !rxf_empty_i && out_ready_i;
                end
                StStat: begin
                    out_valid_o = 1'b1;
                    out_data_o  = status_q;
                end
                default: ;
            endcase
        end
    end

    assign txf_wdata_o = in_data_i;
    assign len_o       = len_q;
    assign op_o        = op_q;

endmodule
